rate_mod_counter: RTL and testbench

- Parametrised modulo counter with a built-in prescaler. It generalises the fixed-width display counters (x scan, y scan, rate divider) into one block.
- Counts 0..MAX_VALUE inclusive, up or down, in wrap or saturate mode.
- Supports synchronous load and clear, and emits a registered terminal pulse for cascading.
- Used for pixel x/y scan addressing and for slow animation ticks in the display path.

---
 rtl/rate_mod_counter_pkg.sv | 25 ++
 rtl/rate_mod_counter_tick_prescaler.sv | 49 ++++
 rtl/rate_mod_counter.sv | 99 +++++++++
 tb/tb_rate_mod_counter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_mod_counter_pkg.sv
// Shared display-path constants and helpers for scan and rate counters.
package rate_mod_counter_pkg;

    // Scan limits for the pixel address counters.
    localparam int SCAN_X_MAX = 7;
    localparam int SCAN_Y_MAX = 192;

    // Prescale factor used for slow animation ticks.
    localparam int ANIM_DIV = 16;

    // Boundary behaviour selectors for the SATURATE parameter.
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rate_mod_counter_tick_prescaler.sv
// Divide-by-DIV prescaler: emits a step strobe every DIV enabled cycles.
module tick_prescaler
    import rate_mod_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic clear_b,
    input  logic enable,
    input  logic sync_clear,
    output logic tick
);

    localparam int PW = clog2_min1(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};

    logic [PW-1:0] p_r;
    logic [PW-1:0] p_next_s;

    // Next phase: clear has priority, otherwise advance modulo DIV while enabled.
    always_comb begin
        p_next_s = p_r;
        if (sync_clear) begin
            p_next_s = P_ZERO;
        end else if (enable) begin
            if (p_r == P_LAST) begin
                p_next_s = P_ZERO;
            end else begin
                p_next_s = p_r + PW'(1);
            end
        end else begin
            p_next_s = p_r;
        end
    end

    // Phase register with asynchronous reset.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            p_r <= P_ZERO;
        end else begin
            p_r <= p_next_s;
        end
    end

    // Strobe on the last phase of an enabled cycle (DIV = 1 reduces to enable).
    assign tick = enable && (p_r == P_LAST);

endmodule

// File: rtl/rate_mod_counter.sv
// Modulo 0..MAX_VALUE up/down counter with prescaler, load/clear and a
// registered terminal-count pulse for cascading into an outer counter.
module rate_mod_counter
    import rate_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = SCAN_Y_MAX,
    parameter int DIV       = 1,
    parameter int SATURATE  = CNT_WRAP
) (
    input  logic             clock,
    input  logic             clear_b,
    input  logic             enable,
    input  logic             up,
    input  logic             sync_clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
    localparam logic             HOLD_AT_BOUNDARY = (SATURATE != 32'sd0);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             tc_r;
    logic             tc_next_s;
    logic             tick_s;
    logic             p_clear_s;
    logic [WIDTH-1:0] load_clamped_s;

    // A load restarts the prescale phase exactly like a clear does.
    assign p_clear_s = sync_clear | load;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock      (clock),
        .clear_b    (clear_b),
        .enable     (enable),
        .sync_clear (p_clear_s),
        .tick       (tick_s)
    );

    // Loaded values above the top of the range are pinned to MAX_VALUE.
    assign load_clamped_s = (load_value > MAX_Q) ? MAX_Q : load_value;

    // Next count and terminal pulse: clear > load > step > hold; tc is a one-cycle pulse.
    always_comb begin
        q_next_s  = q_r;
        tc_next_s = 1'b0;
        if (sync_clear) begin
            q_next_s = ZERO_Q;
        end else if (load) begin
            q_next_s = load_clamped_s;
        end else if (tick_s) begin
            if (up) begin
                if (q_r == MAX_Q) begin
                    tc_next_s = 1'b1;
                    q_next_s  = HOLD_AT_BOUNDARY ? q_r : ZERO_Q;
                end else begin
                    q_next_s = q_r + WIDTH'(1);
                end
            end else begin
                if (q_r == ZERO_Q) begin
                    tc_next_s = 1'b1;
                    q_next_s  = HOLD_AT_BOUNDARY ? q_r : MAX_Q;
                end else begin
                    q_next_s = q_r - WIDTH'(1);
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Count and terminal-pulse registers with asynchronous reset.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            q_r  <= ZERO_Q;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_next_s;
            tc_r <= tc_next_s;
        end
    end

    assign q      = q_r;
    assign tc     = tc_r;
    assign tick   = tick_s;
    assign at_max = (q_r == MAX_Q);
    assign at_min = (q_r == ZERO_Q);

endmodule

// File: tb/tb_rate_mod_counter.sv
// Bench for rate_mod_counter: four configurations driven in parallel, each
// compared every cycle against an arithmetic reference model, plus directed
// tables and sequences for the wrap, prescale, saturate, load, gating and
// asynchronous reset corner cases.
module tb_rate_mod_counter;

    typedef struct {
        int q;
        int p;
        bit tc;
    } mstate_t;

    typedef struct {
        bit en;
        bit up;
        int exp_q;
        bit exp_tc;
        bit exp_max;
    } vec_t;

    logic       clock;
    logic       clear_b;
    logic       enable;
    logic       up;
    logic       sync_clear;
    logic       load;
    logic [7:0] load_value;

    logic [2:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] q3;
    logic [3:0] tick_v;
    logic [3:0] tc_v;
    logic [3:0] amax_v;
    logic [3:0] amin_v;
    logic [3:0] tick_seen;

    int checks   = 0;
    int failures = 0;
    mstate_t ms[4];
    vec_t t1[9];

    // d0: 3-bit wrap 0..7, d1: 0..192 DIV 4, d2: saturate 0..5, d3: 0..192 DIV 3
    rate_mod_counter #(.WIDTH(3), .MAX_VALUE(7), .DIV(1), .SATURATE(0)) d0 (
        .clock(clock), .clear_b(clear_b), .enable(enable), .up(up),
        .sync_clear(sync_clear), .load(load), .load_value(load_value[2:0]),
        .q(q0), .tick(tick_v[0]), .tc(tc_v[0]), .at_max(amax_v[0]), .at_min(amin_v[0]));
    rate_mod_counter #(.WIDTH(8), .MAX_VALUE(192), .DIV(4), .SATURATE(0)) d1 (
        .clock(clock), .clear_b(clear_b), .enable(enable), .up(up),
        .sync_clear(sync_clear), .load(load), .load_value(load_value),
        .q(q1), .tick(tick_v[1]), .tc(tc_v[1]), .at_max(amax_v[1]), .at_min(amin_v[1]));
    rate_mod_counter #(.WIDTH(8), .MAX_VALUE(5), .DIV(1), .SATURATE(1)) d2 (
        .clock(clock), .clear_b(clear_b), .enable(enable), .up(up),
        .sync_clear(sync_clear), .load(load), .load_value(load_value),
        .q(q2), .tick(tick_v[2]), .tc(tc_v[2]), .at_max(amax_v[2]), .at_min(amin_v[2]));
    rate_mod_counter #(.WIDTH(8), .MAX_VALUE(192), .DIV(3), .SATURATE(0)) d3 (
        .clock(clock), .clear_b(clear_b), .enable(enable), .up(up),
        .sync_clear(sync_clear), .load(load), .load_value(load_value),
        .q(q3), .tick(tick_v[3]), .tc(tc_v[3]), .at_max(amax_v[3]), .at_min(amin_v[3]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int cfg_w(int k);
        return (k == 0) ? 3 : 8;
    endfunction

    function automatic int cfg_max(int k);
        case (k)
            0: return 7;
            2: return 5;
            default: return 192;
        endcase
    endfunction

    function automatic int cfg_div(int k);
        case (k)
            1: return 4;
            3: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfg_sat(int k);
        return (k == 2);
    endfunction

    function automatic int act_q(int k);
        case (k)
            0: return int'(q0);
            1: return int'(q1);
            2: return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    // Reference step: counting is arithmetic modulo MAX+1, prescale modulo DIV.
    function automatic mstate_t mstep(mstate_t s, int k, bit en, bit u, bit sc, bit ld, int lv);
        mstate_t n;
        int mx;
        int lvm;
        bit tk;
        mx  = cfg_max(k);
        lvm = (lv % 256) % (1 << cfg_w(k));
        tk  = en && (s.p == cfg_div(k) - 1);
        n    = s;
        n.tc = 1'b0;
        if (en) n.p = (s.p + 1) % cfg_div(k);
        if (sc) begin
            n.q = 0;
            n.p = 0;
        end else if (ld) begin
            n.q = (lvm > mx) ? mx : lvm;
            n.p = 0;
        end else if (tk) begin
            if (u) begin
                n.tc = (s.q == mx);
                n.q  = (cfg_sat(k) && s.q == mx) ? s.q : (s.q + 1) % (mx + 1);
            end else begin
                n.tc = (s.q == 0);
                n.q  = (cfg_sat(k) && s.q == 0) ? s.q : (s.q + mx) % (mx + 1);
            end
        end
        return n;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) ms[k] = '{q: 0, p: 0, tc: 1'b0};
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("model_q[%0d]", k), act_q(k), ms[k].q);
            check($sformatf("model_tc[%0d]", k), int'(tc_v[k]), int'(ms[k].tc));
            check($sformatf("model_at_max[%0d]", k), int'(amax_v[k]), int'(ms[k].q == cfg_max(k)));
            check($sformatf("model_at_min[%0d]", k), int'(amin_v[k]), int'(ms[k].q == 0));
        end
    endtask

    // One clock: drive, check tick at the falling edge, step the model, check after the rising edge.
    task automatic cyc(bit en, bit u, bit sc, bit ld, int lv);
        enable     = en;
        up         = u;
        sync_clear = sc;
        load       = ld;
        load_value = 8'(lv);
        @(negedge clock);
        tick_seen = tick_v;
        for (int k = 0; k < 4; k++)
            check($sformatf("model_tick[%0d]", k), int'(tick_v[k]),
                  int'(en && (ms[k].p == cfg_div(k) - 1)));
        @(posedge clock);
        for (int k = 0; k < 4; k++) ms[k] = mstep(ms[k], k, en, u, sc, ld, lv);
        #1;
        check_outputs();
    endtask

    initial begin
        clear_b    = 1'b0;
        enable     = 1'b0;
        up         = 1'b1;
        sync_clear = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        tick_seen  = 4'd0;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            t1[i].en      = 1'b1;
            t1[i].up      = 1'b1;
            t1[i].exp_q   = (i + 1) % 8;
            t1[i].exp_tc  = (i == 7);
            t1[i].exp_max = (i == 6);
        end

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_q[%0d]", k), act_q(k), 0);
            check($sformatf("reset_tc[%0d]", k), int'(tc_v[k]), 0);
            check($sformatf("reset_at_min[%0d]", k), int'(amin_v[k]), 1);
        end
        @(negedge clock);
        clear_b = 1'b1;
        @(posedge clock);
        #1;

        // 1. Wrap up on the 0..7 counter
        for (int i = 0; i < 9; i++) begin
            cyc(t1[i].en, t1[i].up, 1'b0, 1'b0, 0);
            check($sformatf("t1_q[%0d]", i), int'(q0), t1[i].exp_q);
            check($sformatf("t1_tc[%0d]", i), int'(tc_v[0]), int'(t1[i].exp_tc));
            check($sformatf("t1_at_max[%0d]", i), int'(amax_v[0]), int'(t1[i].exp_max));
        end

        // 2. Prescaled down count 0 -> 192 -> 191
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
            check($sformatf("t2_tick[%0d]", i), int'(tick_seen[1]), int'(i % 4 == 0));
            check($sformatf("t2_q[%0d]", i), int'(q1), (i < 4) ? 0 : ((i < 8) ? 192 : 191));
            check($sformatf("t2_tc[%0d]", i), int'(tc_v[1]), int'(i == 4));
        end

        // 3. Saturate at 5, then step down
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
            check($sformatf("t3_q[%0d]", i), int'(q2), 5);
            check($sformatf("t3_tc[%0d]", i), int'(tc_v[2]), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("t3_q_down", int'(q2), 4);
        check("t3_tc_down", int'(tc_v[2]), 0);

        // 4. Load beats a tick, clamps, and restarts the prescaler
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 250);
        check("t4_tick_in_load", int'(tick_seen[1]), 1);
        check("t4_q_clamped", int'(q1), 192);
        check("t4_tc", int'(tc_v[1]), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
            check($sformatf("t4_q_hold[%0d]", i), int'(q1), 192);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("t4_q_wrap", int'(q1), 0);
        check("t4_tc_wrap", int'(tc_v[1]), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 100);
        check("t4_clear_over_load", int'(q1), 0);

        // 5. Enable gating with DIV 3
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 0 || i >= 3), 1'b1, 1'b0, 1'b0, 0);
            check($sformatf("t5_tick[%0d]", i), int'(tick_seen[3]), int'(i == 4));
            check($sformatf("t5_q[%0d]", i), int'(q3), (i == 4) ? 1 : 0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 192);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
            check($sformatf("t5_idle_q[%0d]", i), int'(q3), 192);
            check($sformatf("t5_idle_max[%0d]", i), int'(amax_v[3]), 1);
        end

        // 6. Asynchronous reset between edges
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 99);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("t6_q_before", int'(q3), 100);
        enable = 1'b0;
        load   = 1'b0;
        #2;
        clear_b = 1'b0;
        #1;
        model_reset();
        check("t6_q_async", int'(q3), 0);
        check("t6_tc_async", int'(tc_v), 0);
        @(negedge clock);
        clear_b = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 4; k++) ms[k] = mstep(ms[k], k, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        #1;
        check_outputs();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("t6_first_tick", int'(q3), 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
